// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared client IDs, FSM state type and sizing helpers for mem_arbiter.
package mem_arbiter_pkg;
    localparam int DEF_MEM_DATA_BITS = 128;
    localparam int DEF_MEM_ADDR_BITS = 28;
    localparam int DEF_DATA_BEATS = 4;
    localparam int DEF_ID_FIFO_DEPTH = 4;
    localparam logic CLIENT_IC = 1'b0;
    localparam logic CLIENT_DC = 1'b1;
    typedef enum logic {IDLE, WDATA} state_t;
    function automatic int ceil_log2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction
    localparam int BEAT_BITS = ceil_log2(DEF_DATA_BEATS);
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and memory-side ports of mem_arbiter; slave is the arbiter, master the environment.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
    parameter int MEM_DATA_BITS = DEF_MEM_DATA_BITS,
    parameter int MEM_ADDR_BITS = DEF_MEM_ADDR_BITS
) ();
    logic                       ic_req_val;
    logic                       ic_req_rdy;
    logic [MEM_ADDR_BITS-1:0]   ic_req_addr;
    logic                       ic_resp_val;
    logic [MEM_DATA_BITS-1:0]   ic_resp_data;
    logic                       dc_req_val;
    logic                       dc_req_rdy;
    logic [MEM_ADDR_BITS-1:0]   dc_req_addr;
    logic                       dc_req_rw;
    logic                       dc_req_data_valid;
    logic                       dc_req_data_ready;
    logic [MEM_DATA_BITS-1:0]   dc_req_data_bits;
    logic [MEM_DATA_BITS/8-1:0] dc_req_data_mask;
    logic                       dc_resp_val;
    logic [MEM_DATA_BITS-1:0]   dc_resp_data;
    logic                       mem_req_val;
    logic                       mem_req_rdy;
    logic [MEM_ADDR_BITS-1:0]   mem_req_addr;
    logic                       mem_req_rw;
    logic                       mem_req_data_valid;
    logic                       mem_req_data_ready;
    logic [MEM_DATA_BITS-1:0]   mem_req_data_bits;
    logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask;
    logic                       mem_resp_val;
    logic [MEM_DATA_BITS-1:0]   mem_resp_data;
    logic                       resp_orphan;
    modport slave (
        input  ic_req_val, ic_req_addr, dc_req_val, dc_req_addr, dc_req_rw,
               dc_req_data_valid, dc_req_data_bits, dc_req_data_mask,
               mem_req_rdy, mem_req_data_ready, mem_resp_val, mem_resp_data,
        output ic_req_rdy, ic_resp_val, ic_resp_data, dc_req_rdy, dc_req_data_ready,
               dc_resp_val, dc_resp_data, mem_req_val, mem_req_addr, mem_req_rw,
               mem_req_data_valid, mem_req_data_bits, mem_req_data_mask, resp_orphan
    );
    modport master (
        output ic_req_val, ic_req_addr, dc_req_val, dc_req_addr, dc_req_rw,
               dc_req_data_valid, dc_req_data_bits, dc_req_data_mask,
               mem_req_rdy, mem_req_data_ready, mem_resp_val, mem_resp_data,
        input  ic_req_rdy, ic_resp_val, ic_resp_data, dc_req_rdy, dc_req_data_ready,
               dc_resp_val, dc_resp_data, mem_req_val, mem_req_addr, mem_req_rw,
               mem_req_data_valid, mem_req_data_bits, mem_req_data_mask, resp_orphan
    );
endinterface

// File: rtl/mem_arbiter_id_fifo.sv
// mem_arbiter_id_fifo: synchronous FIFO of 1-bit client IDs recording outstanding reads in issue order.
module mem_arbiter_id_fifo import mem_arbiter_pkg::*; #(
    parameter int DEPTH = DEF_ID_FIFO_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int AW = ceil_log2(DEPTH);
    logic [DEPTH-1:0] r_mem;
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty = r_wp == r_rp;
    assign full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
    assign dout  = r_mem[r_rp[AW-1:0]];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wp[AW-1:0]] <= din;
                r_wp <= r_wp + 1'b1;
            end
            if (pop) r_rp <= r_rp + 1'b1;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges icache/dcache memory ports onto one memory port and steers in-order read responses back.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed dcache-over-icache priority.
module mem_arbiter import mem_arbiter_pkg::*; #(
    parameter int DATA_BEATS    = DEF_DATA_BEATS,
    parameter int ID_FIFO_DEPTH = DEF_ID_FIFO_DEPTH
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int BW = (ceil_log2(DATA_BEATS) < 1) ? 1 : ceil_log2(DATA_BEATS);
    state_t        r_state;
    state_t        w_next;
    logic [BW-1:0] r_wcnt;
    logic [BW-1:0] r_rcnt;
    logic          r_orphan;
    logic          w_idle;
    logic          w_gnt_dc;
    logic          w_gnt_rd;
    logic          w_block;
    logic          w_mem_val;
    logic          w_accept;
    logic          w_whs;
    logic          w_wlast;
    logic          w_hit;
    logic          w_pop;
    logic          w_head;
    logic          w_full;
    logic          w_empty;
`ifdef MEM_ARB_RR_EN
    logic r_last;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_last <= CLIENT_IC;
        else if (w_accept) r_last <= w_gnt_dc;
    end
    assign w_gnt_dc = bus.dc_req_val && (!bus.ic_req_val || r_last == CLIENT_IC);
`else
    assign w_gnt_dc = bus.dc_req_val;
`endif
    assign w_idle    = r_state == IDLE;
    assign w_gnt_rd  = !(w_gnt_dc && bus.dc_req_rw);
    // A final-beat pop frees a slot in the same cycle, so a read may still go out.
    assign w_block   = w_gnt_rd && w_full && !w_pop;
    assign w_mem_val = !reset && w_idle && (bus.dc_req_val || bus.ic_req_val) && !w_block;
    assign w_accept  = w_mem_val && bus.mem_req_rdy;
    assign w_whs     = !w_idle && bus.dc_req_data_valid && bus.mem_req_data_ready;
    assign w_wlast   = w_whs && r_wcnt == BW'(DATA_BEATS - 1);
    assign w_hit     = bus.mem_resp_val && !w_empty;
    assign w_pop     = w_hit && r_rcnt == BW'(DATA_BEATS - 1);
    assign bus.mem_req_val        = w_mem_val;
    assign bus.dc_req_rdy         = w_accept && w_gnt_dc;
    assign bus.ic_req_rdy         = w_accept && !w_gnt_dc;
    assign bus.mem_req_addr       = w_gnt_dc ? bus.dc_req_addr : bus.ic_req_addr;
    assign bus.mem_req_rw         = w_gnt_dc && bus.dc_req_rw;
    assign bus.mem_req_data_valid = !w_idle && bus.dc_req_data_valid;
    assign bus.dc_req_data_ready  = !w_idle && bus.mem_req_data_ready;
    assign bus.mem_req_data_bits  = bus.dc_req_data_bits;
    assign bus.mem_req_data_mask  = bus.dc_req_data_mask;
    assign bus.ic_resp_data       = bus.mem_resp_data;
    assign bus.dc_resp_data       = bus.mem_resp_data;
    assign bus.ic_resp_val        = w_hit && w_head == CLIENT_IC;
    assign bus.dc_resp_val        = w_hit && w_head == CLIENT_DC;
    assign bus.resp_orphan        = r_orphan;
    always_comb begin
        w_next = w_idle ? ((w_accept && !w_gnt_rd) ? WDATA : IDLE) : (w_wlast ? IDLE : WDATA);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_wcnt   <= '0;
            r_rcnt   <= '0;
            r_orphan <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept && !w_gnt_rd) r_wcnt <= '0;
            else if (w_whs) r_wcnt <= r_wcnt + 1'b1;
            if (w_hit) r_rcnt <= w_pop ? '0 : r_rcnt + 1'b1;
            if (bus.mem_resp_val && w_empty) r_orphan <= 1'b1;
        end
    end
    mem_arbiter_id_fifo #(.DEPTH(ID_FIFO_DEPTH)) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_accept && w_gnt_rd),
        .pop   (w_pop),
        .din   (w_gnt_dc),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction and data caches. Merges their two miss/writeback memory ports onto the single shared memory port.
- Arbitrates between requests and forwards multi-beat write data for the granted client.
- Memory returns read responses in order. The block tracks outstanding reads in an ID FIFO and steers each response beat back to the cache that issued it.

Parameters:
- MEM_DATA_BITS, 128, width of one memory data beat.
- MEM_ADDR_BITS, 28, line-granular memory address width.
- DATA_BEATS, 4, beats per line transfer (read response and write data).
- ID_FIFO_DEPTH, 4, maximum outstanding reads; power of two, at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ic_req_val  in  1  icache read request valid
- ic_req_rdy  out  1  icache request accepted this cycle
- ic_req_addr  in  MEM_ADDR_BITS  icache line address
- ic_resp_val  out  1  response beat for icache
- ic_resp_data  out  MEM_DATA_BITS  response beat data
- dc_req_val  in  1  dcache request valid
- dc_req_rdy  out  1  dcache request accepted
- dc_req_addr  in  MEM_ADDR_BITS  dcache line address
- dc_req_rw  in  1  1 = write, 0 = read
- dc_req_data_valid  in  1  dcache write data beat valid
- dc_req_data_ready  out  1  write beat accepted
- dc_req_data_bits  in  MEM_DATA_BITS  write beat
- dc_req_data_mask  in  MEM_DATA_BITS/8  byte mask
- dc_resp_val  out  1  response beat for dcache
- dc_resp_data  out  MEM_DATA_BITS  response beat data
- mem_req_val  out  1  memory request valid
- mem_req_rdy  in  1  memory accepts request
- mem_req_addr  out  MEM_ADDR_BITS  forwarded address
- mem_req_rw  out  1  forwarded rw; 0 for icache
- mem_req_data_valid  out  1  write beat valid
- mem_req_data_ready  in  1  memory accepts beat
- mem_req_data_bits  out  MEM_DATA_BITS  write beat
- mem_req_data_mask  out  MEM_DATA_BITS/8  byte mask
- mem_resp_val  in  1  read response beat valid
- mem_resp_data  in  MEM_DATA_BITS  read response beat
- resp_orphan  out  1  sticky: a response beat arrived with no outstanding read

Behaviour:
- Reset: asynchronous, active-high.
  - State IDLE, ID FIFO empty, response beat count 0, write beat count 0, resp_orphan 0.
  - While reset is high, every val, rdy and ready output is 0.
- FSM states: IDLE and WDATA.
- IDLE, request path:
  - The grant is chosen combinationally from registered state, with fixed priority dcache over icache.
  - mem_req_val = granted client's val.
  - A read is blocked (mem_req_val = 0) when the ID FIFO is full. A write is never blocked by the FIFO.
  - Granted rdy = mem_req_val & mem_req_rdy. The other client's rdy = 0.
  - Zero-cycle pass-through: address and rw are combinational from the granted client.
- On an accepted read: push the client ID (0 = icache, 1 = dcache) into the FIFO.
- On an accepted write: go to WDATA and clear the write beat counter.
- WDATA:
  - mem_req_val = 0 and both req_rdy = 0.
  - Data, mask and valid pass through from the dcache; dc_req_data_ready = mem_req_data_ready.
  - Each handshake increments the write beat counter.
  - On the handshake of beat DATA_BEATS-1, return to IDLE on the next cycle. A new request may be accepted no earlier than that cycle.
  - In IDLE, mem_req_data_valid = 0 and dc_req_data_ready = 0.
- Response path (independent of FSM state):
  - mem_resp_data fans out to both resp_data outputs unconditionally.
  - When mem_resp_val is high and the FIFO is non-empty, the resp_val selected by the FIFO head is asserted in the same cycle.
  - The response beat counter increments per beat and wraps at DATA_BEATS-1.
  - The FIFO pops on the final beat.
- Simultaneous final-beat pop and read push: both take effect; occupancy is unchanged. Pushing while full is impossible by construction.
- Orphan beat: mem_resp_val with the FIFO empty. Neither resp_val asserts, resp_orphan sets and holds until reset, and the counter is unchanged.
- Reset mid-transfer: all state is discarded. Partial lines and outstanding reads are lost; the caches are reset together.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration with a 1-bit last-grant register; reset value makes dcache preferred first.
  - When both clients request, grant the one not granted last.
  - The register updates only on an accepted request.
- Undefined: fixed dcache-over-icache priority with no pointer register.

Decomposition:
- Shared package holds:
  - client ID constants CLIENT_IC = 0, CLIENT_DC = 1;
  - FSM state typedef (IDLE, WDATA);
  - the beat-count width, derived as ceilLog2(DATA_BEATS).
- One natural sub-module: id_fifo, a synchronous FIFO of 1-bit entries.
  - Ports: push, pop, din, dout, full, empty.
  - Async active-high reset.
  - Same-cycle push and pop allowed when full or empty per the rules above.

Test Plan:
- Simultaneous requests, mem_req_rdy = 1: ic_req_val = 1 and dc read at 0x0000040 -> dc_req_rdy = 1, ic_req_rdy = 0, mem_req_addr = 0x0000040. The icache is granted the next cycle. With MEM_ARB_RR_EN, grants alternate on repeated contention.
- Interleaved reads: ic read then dc read; memory returns 8 beats with values 0..7 -> ic_resp_val on beats 0..3 only, dc_resp_val on beats 4..7 only, FIFO empty afterwards.
- Dcache write with 4 beats, mem_req_data_ready toggling 1,0,1,1,0,1 -> exactly 4 data handshakes with matching bits and mask. A concurrent ic_req_val sees ic_req_rdy = 0 until the cycle after the last beat.
- FIFO full: issue 4 reads with no responses -> the 5th read has mem_req_val = 0. On the final beat of the first response the 5th is accepted in the same cycle.
- Orphan: mem_resp_val = 1 with no outstanding reads -> both resp_val = 0, resp_orphan = 1 and held. Asserting reset for one cycle clears it.
- Reset mid-WDATA after 2 beats -> FSM returns to IDLE and the beat counter is 0. A following write transfers all 4 beats correctly.
